// File: rtl/res_frame_capture.sv
// Result frame capture: fills a NUM-item buffer from the per-cycle result
// stream while keeping a running checksum. Once full, it drains the frame
// over a valid/ready port and then returns to filling.
module res_frame_capture #(
  parameter int unsigned NUM        = 1000,
  parameter int unsigned ITEM_WIDTH = 8,
  parameter int unsigned SUM_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  in_valid_i,
  input  logic [ITEM_WIDTH-1:0] in_data_i,
  input  logic                  drain_en_i,
  output logic                  out_valid_o,
  output logic [ITEM_WIDTH-1:0] out_data_o,
  input  logic                  out_ready_i,
  output logic                  frame_done_o,
  output logic                  busy_o,
  output logic [SUM_WIDTH-1:0]  checksum_o,
  output logic [15:0]           drop_cnt_o
);

  localparam int unsigned PTR_W  = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int unsigned DROP_W = 16;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM - 1);

  typedef enum logic [1:0] {FILL, FULL, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [SUM_WIDTH-1:0]  sum_q, sum_d;
  logic [DROP_W-1:0]     drop_q, drop_d;
  logic                  out_valid_q, out_valid_d;
  logic [ITEM_WIDTH-1:0] out_data_q, out_data_d;
  logic                  frame_done_q, frame_done_d;
  logic                  busy_q, busy_d;
  logic                  wr_en_c;

  logic [ITEM_WIDTH-1:0] mem [NUM];

  // Next-state and next-output logic for the fill/full/drain sequence.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    sum_d        = sum_q;
    drop_d       = drop_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;
    wr_en_c      = 1'b0;

    // Samples arriving outside FILL are discarded but counted.
    if ((state_q != FILL) && in_valid_i && (drop_q != '1)) begin
      drop_d = drop_q + DROP_W'(1);
    end

    case (state_q)
      FILL: begin
        if (in_valid_i) begin
          wr_en_c = 1'b1;
          sum_d   = sum_q + SUM_WIDTH'(in_data_i);
          if (wr_ptr_q == LAST_IDX) begin
            state_d      = FULL;
            frame_done_d = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end
        end
      end
      FULL: begin
        if (drain_en_i) begin
          state_d     = DRAIN;
          rd_ptr_d    = '0;
          out_valid_d = 1'b1;
          out_data_d  = mem[0];
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready_i) begin
          if (rd_ptr_q == LAST_IDX) begin
            state_d     = FILL;
            out_valid_d = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            sum_d       = '0;
          end else begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            out_data_d = mem[rd_ptr_q + PTR_W'(1)];
          end
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase

    busy_d = (state_d != FILL);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= FILL;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      sum_q        <= '0;
      drop_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      sum_q        <= sum_d;
      drop_q       <= drop_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  // Frame buffer storage; contents are not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_c) begin
      mem[wr_ptr_q] <= in_data_i;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = busy_q;
  assign checksum_o   = sum_q;
  assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_res_frame_capture.sv
// Self-checking bench for res_frame_capture (NUM=4, 8-bit items, 8-bit sum).
module tb_res_frame_capture;

  localparam int unsigned NUM = 4;
  localparam int unsigned IW  = 8;
  localparam int unsigned SW  = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic [IW-1:0] in_data;
  logic          drain_en;
  logic          out_valid;
  logic [IW-1:0] out_data;
  logic          out_ready;
  logic          frame_done;
  logic          busy;
  logic [SW-1:0] checksum;
  logic [15:0]   drop_cnt;

  res_frame_capture #(.NUM(NUM), .ITEM_WIDTH(IW), .SUM_WIDTH(SW)) dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .in_valid_i   (in_valid),
    .in_data_i    (in_data),
    .drain_en_i   (drain_en),
    .out_valid_o  (out_valid),
    .out_data_o   (out_data),
    .out_ready_i  (out_ready),
    .frame_done_o (frame_done),
    .busy_o       (busy),
    .checksum_o   (checksum),
    .drop_cnt_o   (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a frame is a queue of captured items; phase 0=filling,
  // 1=frame held, 2=handing items out one by one.
  int           m_phase;
  bit [IW-1:0]  m_cap[$];
  int           m_idx;
  bit           m_fd;
  int           m_drops;

  logic [IW-1:0] rx[$];
  logic [IW-1:0] sent[$];

  typedef struct {
    bit          v;
    bit [IW-1:0] d;
    bit          dr;
    bit          rdy;
    bit          e_valid;
    bit [IW-1:0] e_data;
    bit          e_done;
    bit          e_busy;
    bit [SW-1:0] e_sum;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int m_sum();
    int s = 0;
    foreach (m_cap[i]) s += int'(m_cap[i]);
    return s % (1 << SW);
  endfunction

  task automatic m_reset();
    m_phase = 0;
    m_cap.delete();
    m_idx   = 0;
    m_fd    = 1'b0;
    m_drops = 0;
  endtask

  task automatic m_step(input bit v, input bit [IW-1:0] d, input bit dr, input bit rdy);
    m_fd = 1'b0;
    if (m_phase == 0) begin
      if (v) begin
        m_cap.push_back(d);
        if (m_cap.size() == int'(NUM)) begin
          m_phase = 1;
          m_fd    = 1'b1;
        end
      end
    end else begin
      if (v && m_drops < 32'hFFFF) m_drops++;
      if (m_phase == 1) begin
        if (dr) begin
          m_phase = 2;
          m_idx   = 0;
        end
      end else if (rdy) begin
        m_idx++;
        if (m_idx == int'(NUM)) begin
          m_phase = 0;
          m_cap.delete();
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_phase == 2));
    if (m_phase == 2) chk({tag, ".data"}, 32'(out_data), 32'(m_cap[m_idx]));
    chk({tag, ".done"}, 32'(frame_done), 32'(m_fd));
    chk({tag, ".busy"}, 32'(busy), 32'(m_phase != 0));
    chk({tag, ".sum"}, 32'(checksum), 32'(m_sum()));
    chk({tag, ".drops"}, 32'(drop_cnt), 32'(m_drops));
  endtask

  // One clock: apply inputs, advance the model at the edge, compare after it.
  task automatic drive(input string tag, input bit v, input bit [IW-1:0] d,
                       input bit dr, input bit rdy);
    in_valid  = v;
    in_data   = d;
    drain_en  = dr;
    out_ready = rdy;
    if (out_valid === 1'b1 && rdy) rx.push_back(out_data);
    @(posedge clk);
    m_step(v, d, dr, rdy);
    #1;
    check_all(tag);
  endtask

  task automatic fill_sent(input string tag);
    foreach (sent[i]) drive(tag, 1'b1, sent[i], 1'b0, 1'b0);
  endtask

  task automatic drain_frame(input string tag, input bit bp);
    bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    rx.delete();
    drive(tag, 1'b0, '0, 1'b1, 1'b1);
    for (int k = 0; k < 40 && m_phase != 0; k++) begin
      drive(tag, 1'b0, '0, 1'b0, bp ? pat[k % 7] : 1'b1);
    end
    chk({tag, ".drain_end_busy"}, 32'(busy), 32'(0));
  endtask

  task automatic compare_rx(input string tag);
    chk({tag, ".rx_count"}, 32'(rx.size()), 32'(sent.size()));
    foreach (sent[i]) begin
      if (i < rx.size()) chk($sformatf("%s.rx[%0d]", tag, i), 32'(rx[i]), 32'(sent[i]));
    end
  endtask

  task automatic hard_reset();
    reset_n = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    drain_en  = 1'b0;
    out_ready = 1'b0;
    m_reset();

    // Basic fill/drain, drain_en during FILL ignored.
    tbl[0] = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h10};
    tbl[1] = '{1'b1, 8'h20, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h30};
    tbl[2] = '{1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h60};
    tbl[3] = '{1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h10, 1'b0, 1'b1, 8'hA0};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 1'b1, 8'hA0};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h30, 1'b0, 1'b1, 8'hA0};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 1'b1, 8'hA0};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};

    repeat (2) @(posedge clk);
    #1;
    chk("reset.valid", 32'(out_valid), 32'(0));
    chk("reset.data", 32'(out_data), 32'(0));
    chk("reset.done", 32'(frame_done), 32'(0));
    chk("reset.busy", 32'(busy), 32'(0));
    chk("reset.sum", 32'(checksum), 32'(0));
    chk("reset.drops", 32'(drop_cnt), 32'(0));
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      in_valid  = tbl[i].v;
      in_data   = tbl[i].d;
      drain_en  = tbl[i].dr;
      out_ready = tbl[i].rdy;
      @(posedge clk);
      m_step(tbl[i].v, tbl[i].d, tbl[i].dr, tbl[i].rdy);
      #1;
      chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) chk($sformatf("vec%0d.data", i), 32'(out_data), 32'(tbl[i].e_data));
      chk($sformatf("vec%0d.done", i), 32'(frame_done), 32'(tbl[i].e_done));
      chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("vec%0d.sum", i), 32'(checksum), 32'(tbl[i].e_sum));
    end

    // Gapped input.
    sent = '{8'd1, 8'd2, 8'd3, 8'd4};
    foreach (sent[i]) begin
      drive("gap", 1'b1, sent[i], 1'b0, 1'b0);
      if (i < 3) repeat ($urandom_range(1, 3)) drive("gap", 1'b0, '0, 1'b0, 1'b0);
    end
    chk("gap.sum", 32'(checksum), 32'h0A);
    drain_frame("gap", 1'b0);
    compare_rx("gap");

    // Backpressure during drain.
    sent.delete();
    repeat (NUM) sent.push_back(IW'($urandom));
    fill_sent("bp");
    drain_frame("bp", 1'b1);
    compare_rx("bp");

    // Drops in FULL and DRAIN, then a fresh frame from index 0.
    hard_reset();
    sent = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
    fill_sent("drop");
    repeat (3) drive("drop", 1'b1, IW'($urandom), 1'b0, 1'b0);
    rx.delete();
    drive("drop", 1'b0, '0, 1'b1, 1'b0);
    repeat (2) drive("drop", 1'b1, IW'($urandom), 1'b0, 1'b0);
    for (int k = 0; k < 20 && m_phase != 0; k++) drive("drop", 1'b0, '0, 1'b0, 1'b1);
    chk("drop.count", 32'(drop_cnt), 32'd5);
    compare_rx("drop");
    sent = '{8'h01, 8'h80, 8'h7F, 8'hEE};
    fill_sent("next");
    drain_frame("next", 1'b0);
    compare_rx("next");

    // Checksum wrap.
    sent = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    fill_sent("wrap");
    chk("wrap.sum", 32'(checksum), 32'hFC);
    drain_frame("wrap", 1'b0);

    // Asynchronous reset mid-fill.
    drive("rst", 1'b1, 8'h11, 1'b0, 1'b0);
    drive("rst", 1'b1, 8'h22, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    m_reset();
    #1;
    chk("rst.async_busy", 32'(busy), 32'(0));
    chk("rst.async_sum", 32'(checksum), 32'(0));
    chk("rst.async_valid", 32'(out_valid), 32'(0));
    chk("rst.async_drops", 32'(drop_cnt), 32'(0));
    chk("rst.async_data", 32'(out_data), 32'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    sent = '{8'h03, 8'h05, 8'h07, 8'h09};
    fill_sent("rst");
    chk("rst.sum", 32'(checksum), 32'h18);
    drain_frame("rst", 1'b0);
    compare_rx("rst");

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      drive("rand", 1'($urandom_range(0, 1)), IW'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
